aram_fifo_1r1w1ck: RTL
======================

ARAM_FIFO_1R1W1CK -- requirements
Module: aram_fifo_1r1w1ck

Interface
REQ-001 SHALL have parameter WIDTH, default 513, data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 64, entries; power of two, >= 4.
REQ-003 SHALL have parameter AFULL, default DEPTH-4, almost-full threshold in entries.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous empty request.
REQ-007 SHALL have port wr_valid  input  1  write request.
REQ-008 SHALL have port wr_ready  output  1  FIFO can accept (registered).
REQ-009 SHALL have port wr_data  input  WIDTH  write data.
REQ-010 SHALL have port rd_valid  output  1  rd_data holds head entry.
REQ-011 SHALL have port rd_ready  input  1  consumer accepts head.
REQ-012 SHALL have port rd_data  output  WIDTH  head entry, straight from the RAM output register.
REQ-013 SHALL have port count  output  clog2(DEPTH)+1  total entries held, including the entry on rd_data.
REQ-014 SHALL have port almost_full  output  1  count >= AFULL (registered).

Function
REQ-015 Write accepted on an edge with wr_valid & wr_ready & !flush; data stored at wr_ptr; wr_ptr increments mod DEPTH.
REQ-016 Read accepted on an edge with rd_valid & rd_ready & !flush; entry leaves FIFO.
REQ-017 Storage SHALL be a registered-read RAM; a RAM read SHALL be issued when mem_cnt > 0 and (!rd_valid or rd_ready), loading rd_data and setting rd_valid; rd_ptr increments mod DEPTH.
REQ-018 When rd_valid & !rd_ready, no RAM read SHALL be issued and rd_data SHALL hold stable.
REQ-019 Latency: entry written into an empty FIFO at edge N SHALL appear with rd_valid=1 after edge N+1.
REQ-020 Throughput: with wr_valid and rd_ready held high, one entry per cycle in and out, no bubbles after first.
REQ-021 A RAM read SHALL never target the address being written on the same edge (mem_cnt excludes same-edge write); no read-during-write bypass needed.
REQ-022 Capacity DEPTH; wr_ready = (count_next < DEPTH); a pop on the same edge as full does not enable a same-cycle push (wr_ready deasserts for that cycle).
REQ-023 count: +1 on write only, -1 on read only, unchanged on both; never exceeds DEPTH, never wraps below 0.
REQ-024 Pointers wrap DEPTH-1 -> 0 with no lost or duplicated entries.
REQ-025 flush SHALL, at the edge, zero pointers, count, rd_valid, almost_full and set wr_ready=1; write and read on the flush edge ignored.
REQ-026 rd_data content while rd_valid=0 is don't-care.

Reset
REQ-027 reset_n low SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, almost_full=0, wr_ready=1.
REQ-028 RAM array and rd_data register SHALL NOT be reset (block-RAM inference).
REQ-029 Reset asserted mid-traffic discards all contents; first write after release behaves per REQ-019.

Structure
REQ-030 Shared package holds pointer-width function (clog2) and default WIDTH/DEPTH constants.
REQ-031 One sub-module aram_1r1w1ck_param (WIDTH, DEPTH generic simple dual-port RAM, ena/enb/wea, registered enabled read) holds storage; control logic lives in the top.

Verification
REQ-032 Reset, write 0x1 at cycle 0 -> rd_valid=1, rd_data=0x1 after next edge, count=1.
REQ-033 DEPTH=64, write 64 entries with rd_ready=0 -> wr_ready=0 after 64th, count=64, almost_full=1 from count 60; 65th write not accepted.
REQ-034 Continuous stream 0..199 with wr_valid=rd_ready=1 -> output 0..199 in order, one per cycle, pointer wrap at 64 and 128 clean.
REQ-035 Random rd_ready stalls, 1000 entries -> in-order, lossless; rd_data stable whenever rd_valid & !rd_ready.
REQ-036 Fill 10, assert flush with wr_valid=1 -> next cycle count=0, rd_valid=0, wr_ready=1; flush-cycle write absent.
REQ-037 reset_n pulsed low mid-stream between edges -> outputs reach reset values immediately, before next edge.

Source files
------------

// File: rtl/aram_fifo_1r1w1ck_pkg.sv
// Shared constants and helpers for the registered-read RAM FIFO.
package aram_fifo_1r1w1ck_pkg;

  localparam int unsigned DEF_WIDTH = 513;
  localparam int unsigned DEF_DEPTH = 64;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/aram_fifo_1r1w1ck_ram.sv
// Simple dual-port RAM: port A write, port B enabled registered read, no reset.
module aram_1r1w1ck_param
  import aram_fifo_1r1w1ck_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      ena,
  input  logic                      wea,
  input  logic [clog2(DEPTH)-1:0]   addra,
  input  logic [WIDTH-1:0]          dina,
  input  logic                      enb,
  input  logic [clog2(DEPTH)-1:0]   addrb,
  output logic [WIDTH-1:0]          doutb
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ena && wea) mem[addra] <= dina;
    if (enb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/aram_fifo_1r1w1ck.sv
// Single-clock FIFO built on a registered-read RAM; rd_data is the RAM output register.
module aram_fifo_1r1w1ck
  import aram_fifo_1r1w1ck_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AFULL = DEPTH - 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WIDTH-1:0]        rd_data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    almost_full
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt, mem_cnt_next, count_next;
  logic          wr_en, pop, rd_issue;

  // mem_cnt counts entries still in the array (not the head in rd_data) and
  // excludes this edge's write, so a read never targets the write address.
  always_comb begin
    wr_en    = wr_valid & wr_ready & ~flush;
    pop      = rd_valid & rd_ready & ~flush;
    rd_issue = (mem_cnt != '0) & (~rd_valid | rd_ready) & ~flush;

    count_next = count;
    if (wr_en && !pop)      count_next = count + CW'(1);
    else if (pop && !wr_en) count_next = count - CW'(1);

    mem_cnt_next = mem_cnt;
    if (wr_en && !rd_issue)      mem_cnt_next = mem_cnt + CW'(1);
    else if (rd_issue && !wr_en) mem_cnt_next = mem_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      count       <= '0;
      rd_valid    <= 1'b0;
      almost_full <= 1'b0;
      wr_ready    <= 1'b1;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      count       <= '0;
      rd_valid    <= 1'b0;
      almost_full <= 1'b0;
      wr_ready    <= 1'b1;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + AW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      if (rd_issue)  rd_valid <= 1'b1;
      else if (pop)  rd_valid <= 1'b0;
      mem_cnt     <= mem_cnt_next;
      count       <= count_next;
      wr_ready    <= (count_next < CW'(DEPTH));
      almost_full <= (count_next >= CW'(AFULL));
    end
  end

  aram_1r1w1ck_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .ena   (wr_en),
    .wea   (1'b1),
    .addra (wr_ptr),
    .dina  (wr_data),
    .enb   (rd_issue),
    .addrb (rd_ptr),
    .doutb (rd_data)
  );

endmodule
